// File: rtl/sram_responder.sv
// Responder end of the MIPS data-memory interface: word array with a post-reset
// zero sweep, an RD_LAT-deep read pipeline and saturating access statistics.
module sram_responder #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  output logic              q_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  // Registered stages ahead of Q; Q itself is the last stage of the read latency.
  localparam int unsigned PipeD = (RD_LAT > 1) ? RD_LAT - 1 : 1;

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_req, wr_req, drop_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_data;

  logic [PipeD-1:0]  pipe_vld_q, pipe_en_q;
  logic [DATA_W-1:0] pipe_data_q [PipeD];

  logic              out_vld, out_en;
  logic [DATA_W-1:0] out_data;

  logic [DATA_W-1:0] q_data_q;
  logic              q_valid_q;
  logic [CNT_W-1:0]  rd_cnt_q, wr_cnt_q, drop_cnt_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    drop_req  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = A;
    mem_wdata = D;
    unique case (state_q)
      StInit: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + ADDR_W'(1);
        drop_req  = ~CEN;
        if (&ptr_q) begin
          state_d = StReady;
        end
      end
      StReady: begin
        rd_req = ~CEN & WEN;
        wr_req = ~CEN & ~WEN;
        mem_we = wr_req;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // No reset on the array; the sweep clears it. A write on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_data = mem[A];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      pipe_en_q  <= '0;
      for (int i = 0; i < PipeD; i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0]  <= rd_req;
      pipe_en_q[0]   <= ~OEN;
      pipe_data_q[0] <= rd_data;
      for (int i = 1; i < PipeD; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_en_q[i]   <= pipe_en_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  always_comb begin
    out_vld  = rd_req;
    out_en   = ~OEN;
    out_data = rd_data;
    if (RD_LAT > 1) begin
      out_vld  = pipe_vld_q[PipeD-1];
      out_en   = pipe_en_q[PipeD-1];
      out_data = pipe_data_q[PipeD-1];
    end
  end

  // A read sampled with OEN high still completes, but drives zero without a valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data_q  <= '0;
      q_valid_q <= 1'b0;
    end else begin
      q_valid_q <= out_vld & out_en;
      if (out_vld) begin
        q_data_q <= out_en ? out_data : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (rd_req && (rd_cnt_q != '1)) begin
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
      if (wr_req && (wr_cnt_q != '1)) begin
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end
      if (drop_req && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
    end
  end

  assign Q          = q_data_q;
  assign q_valid    = q_valid_q;
  assign busy       = (state_q == StInit);
  assign rd_count   = rd_cnt_q;
  assign wr_count   = wr_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: two instances (RD_LAT 1 / 16-bit counters and RD_LAT 3 /
// 3-bit counters) share one stimulus stream and are checked against a behavioural model.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b1;
  logic        wen = 1'b1;
  logic        oen = 1'b0;
  logic [6:0]  a   = '0;
  logic [31:0] d   = '0;

  logic [31:0] q1, q3;
  logic        qv1, qv3, busy1, busy3;
  logic [15:0] rd1, wr1, dr1;
  logic [2:0]  rd3, wr3, dr3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_responder #(.ADDR_W(7), .DATA_W(32), .RD_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .CEN(cen), .WEN(wen), .OEN(oen), .A(a), .D(d),
    .Q(q1), .q_valid(qv1), .busy(busy1),
    .rd_count(rd1), .wr_count(wr1), .drop_count(dr1)
  );

  sram_responder #(.ADDR_W(7), .DATA_W(32), .RD_LAT(3), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .CEN(cen), .WEN(wen), .OEN(oen), .A(a), .D(d),
    .Q(q3), .q_valid(qv3), .busy(busy3),
    .rd_count(rd3), .wr_count(wr3), .drop_count(dr3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    bit          en;
    logic [31:0] data;
  } rd_t;

  logic [31:0] mem_m [128];
  rd_t         pend1 [$];
  rd_t         pend3 [$];
  int          edge_n, init_left;
  int          rd1_m, wr1_m, dr1_m, rd3_m, wr3_m, dr3_m;
  logic [31:0] eq1, eq3;
  bit          ev1, ev3;

  function automatic int sat(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    rd_t r;
    if (rst) begin
      for (int i = 0; i < 128; i++) mem_m[i] = '0;
      pend1.delete();
      pend3.delete();
      edge_n = 0;
      init_left = 128;
      rd1_m = 0; wr1_m = 0; dr1_m = 0;
      rd3_m = 0; wr3_m = 0; dr3_m = 0;
      eq1 = '0; eq3 = '0; ev1 = 0; ev3 = 0;
    end else begin
      edge_n++;
      if (init_left > 0) begin
        if (!cen) begin
          dr1_m = sat(dr1_m, 65535);
          dr3_m = sat(dr3_m, 7);
        end
        init_left--;
      end else if (!cen) begin
        if (!wen) begin
          mem_m[a] = d;
          wr1_m = sat(wr1_m, 65535);
          wr3_m = sat(wr3_m, 7);
        end else begin
          r.en   = !oen;
          r.data = mem_m[a];
          r.due  = edge_n;
          pend1.push_back(r);
          r.due  = edge_n + 2;
          pend3.push_back(r);
          rd1_m = sat(rd1_m, 65535);
          rd3_m = sat(rd3_m, 7);
        end
      end
      ev1 = 0;
      if (pend1.size() > 0 && pend1[0].due == edge_n) begin
        r = pend1.pop_front();
        ev1 = r.en;
        eq1 = r.en ? r.data : 32'h0;
      end
      ev3 = 0;
      if (pend3.size() > 0 && pend3[0].due == edge_n) begin
        r = pend3.pop_front();
        ev3 = r.en;
        eq3 = r.en ? r.data : 32'h0;
      end
    end
  end

  // Compare process: every negedge outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy1", 32'(busy1), 32'(init_left > 0));
      chk("busy3", 32'(busy3), 32'(init_left > 0));
      chk("q_valid1", 32'(qv1), 32'(ev1));
      chk("q_valid3", 32'(qv3), 32'(ev3));
      chk("Q1", q1, eq1);
      chk("Q3", q3, eq3);
      chk("rd_count1", 32'(rd1), rd1_m);
      chk("wr_count1", 32'(wr1), wr1_m);
      chk("drop_count1", 32'(dr1), dr1_m);
      chk("rd_count3", 32'(rd3), rd3_m);
      chk("wr_count3", 32'(wr3), wr3_m);
      chk("drop_count3", 32'(dr3), dr3_m);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic c, input logic w, input logic o,
                     input logic [6:0] ad, input logic [31:0] dd);
    cen = c; wen = w; oen = o; a = ad; d = dd;
    @(negedge clk);
  endtask

  task automatic wr(input logic [6:0] ad, input logic [31:0] dd);
    cyc(1'b0, 1'b0, 1'b0, ad, dd);
  endtask

  task automatic rd(input logic [6:0] ad, input logic o);
    cyc(1'b0, 1'b1, o, ad, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 7'h0, 32'h0);
  endtask

  initial begin
    int   n;
    logic any;
    logic [31:0] rq3 [5];
    logic        rv3 [5];

    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy1), 32'd1);
    chk("rst_q_valid", 32'(qv1), 32'd0);
    chk("rst_Q", q1, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;

    // T1/T2: count edges until busy drops; 5 requests hit the sweep.
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (i < 5) begin
        cen = 1'b0; wen = 1'b0; a = 7'h03; d = 32'hFFFF_FFFF;
      end else begin
        cen = 1'b1;
      end
      @(negedge clk);
      n++;
      if (!busy1) break;
    end
    chk("init_len", n, 32'd128);
    chk("drop_lit", 32'(dr1), 32'd5);
    chk("wr_after_init", 32'(wr1), 32'd0);
    chk("rd_after_init", 32'(rd1), 32'd0);

    rd(7'h03, 1'b0);
    chk("swept_q", q1, 32'h0);
    chk("swept_qv", 32'(qv1), 32'd1);
    rd(7'h7F, 1'b0);

    // T3: write then read next cycle.
    wr(7'h05, 32'hDEAD_BEEF);
    rd(7'h05, 1'b0);
    chk("t3_q", q1, 32'hDEAD_BEEF);
    chk("t3_qv", 32'(qv1), 32'd1);

    // T4: back-to-back reads through the 3-deep instance.
    wr(7'h01, 32'd11);
    wr(7'h02, 32'd22);
    wr(7'h03, 32'd33);
    rd(7'h01, 1'b0); rq3[0] = q3; rv3[0] = qv3;
    rd(7'h02, 1'b0); rq3[1] = q3; rv3[1] = qv3;
    rd(7'h03, 1'b0); rq3[2] = q3; rv3[2] = qv3;
    idle(1);         rq3[3] = q3; rv3[3] = qv3;
    idle(1);         rq3[4] = q3; rv3[4] = qv3;
    chk("t4_qv0", 32'(rv3[0]), 32'd0);
    chk("t4_qv1", 32'(rv3[1]), 32'd0);
    for (int i = 2; i < 5; i++) begin
      chk("t4_qv", 32'(rv3[i]), 32'd1);
      chk("t4_q", rq3[i], 32'd11 * (i - 1));
    end
    idle(2);

    // Read issued before a write returns old data; read after returns new.
    rd(7'h01, 1'b0);
    wr(7'h01, 32'd44);
    idle(1);
    chk("old_data_q3", q3, 32'd11);
    chk("old_data_qv3", 32'(qv3), 32'd1);
    idle(2);
    rd(7'h01, 1'b0);
    chk("new_data_q1", q1, 32'd44);
    idle(3);

    // T5: OEN high read, with Q already zero from a read of a swept word.
    rd(7'h09, 1'b0);
    idle(3);
    rd(7'h09, 1'b1);
    any = qv1 | qv3;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      any = any | qv1 | qv3;
    end
    chk("t5_no_valid", 32'(any), 32'd0);
    chk("t5_q1", q1, 32'h0);
    chk("t5_q3", q3, 32'h0);
    chk("t5_rd1", 32'(rd1), 32'd10);
    chk("t5_rd3_sat", 32'(rd3), 32'd7);

    // T6: saturation, then reset while a read is in flight.
    wr(7'h0A, 32'h1);
    wr(7'h0B, 32'h2);
    wr(7'h0C, 32'h3);
    chk("t6_wr1", 32'(wr1), 32'd8);
    chk("t6_wr3_sat", 32'(wr3), 32'd7);
    idle(1);
    chk("t6_wr3_hold", 32'(wr3), 32'd7);
    rd(7'h05, 1'b0);
    cen = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy3), 32'd1);
    chk("t6_qv3", 32'(qv3), 32'd0);
    chk("t6_wr3", 32'(wr3), 32'd0);
    chk("t6_rd1", 32'(rd1), 32'd0);
    chk("t6_drop1", 32'(dr1), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_qv3_in_rst", 32'(qv3), 32'd0);
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy1) break;
    end
    chk("resweep_done", 32'(busy1), 32'd0);

    rd(7'h05, 1'b0);
    chk("resweep_q", q1, 32'h0);
    chk("resweep_qv", 32'(qv1), 32'd1);
    rd(7'h01, 1'b0);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
